// File: rtl/omp_pkg.sv
// Shared widths, history layout and controller state encoding for the OMP
// residual-update path.
package omp_pkg;

   localparam int ELEM_W     = 16;
   localparam int FRAC       = 14;
   localparam int LANES      = 6;
   localparam int WORD_W     = ELEM_W * LANES;
   localparam int SLOT_W     = 7;
   localparam int HIST_SLOTS = 16;
   localparam int HIST_W     = SLOT_W * HIST_SLOTS;
   localparam int ROW_W      = 3;
   localparam int COL_W      = 6;
   localparam int PROD_W     = 2 * ELEM_W;
   localparam int DIFF_W     = PROD_W - FRAC;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      LAT  = 3'd2,
      MUL  = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/lane_sub_sat.sv
// One element lane: registers phi*coeff and the residual, then produces
// sat16(r - (p >>> FRAC)) combinationally for the write cycle.
module lane_sub_sat
   import omp_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_ld,
   input  logic signed [ELEM_W-1:0] i_phi,
   input  logic signed [ELEM_W-1:0] i_coeff,
   input  logic signed [ELEM_W-1:0] i_r,
   output logic        [ELEM_W-1:0] o_d
);

   logic signed [PROD_W-1:0] r_p;
   logic signed [ELEM_W-1:0] r_r;
   logic signed [DIFF_W-1:0] w_sh;
   logic signed [DIFF_W-1:0] w_d;

   // Capture product and residual while the BRAM words are stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p <= '0;
         r_r <= '0;
      end else if (i_ld) begin
         r_p <= i_phi * i_coeff;
         r_r <= i_r;
      end
   end

   // Full-range product shifted by FRAC always fits 18 bits, so no overflow
   // can occur before the final clamp.
   always_comb begin
      w_sh = DIFF_W'(r_p >>> FRAC);
      w_d  = DIFF_W'(r_r) - w_sh;
      if (w_d > DIFF_W'(32767))
         o_d = 16'h7FFF;
      else if (w_d < -DIFF_W'(32768))
         o_d = 16'h8000;
      else
         o_d = w_d[ELEM_W-1:0];
   end

endmodule

// File: rtl/residual_update.sv
// In-place residual update after atom selection: for every residual row,
// r[k] <= sat16(r[k] - ((phi_lambda[k]*coeff) >>> FRAC)), plus lambda history.
//
// state | meaning
// IDLE  | waiting for start_u; history clear and writes happen here
// RD    | present phi_addr={lambda,row} and r_rd_addr=row
// LAT   | BRAM read latency, addresses held
// MUL   | lanes register phi*coeff and the residual word
// WR    | write saturated result to row; advance or finish
// DONE  | update_done high for one cycle
module residual_update
   import omp_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_u,
   input  logic                   hist_clr,
   input  logic [COL_W-1:0]       lambda,
   input  logic [ELEM_W-1:0]      coeff,
   input  logic [COL_W-1:0]       N,
   input  logic [ROW_W-1:0]       M,
   input  logic [4:0]             current_i,
   output logic [COL_W+ROW_W-1:0] phi_addr,
   input  logic [WORD_W-1:0]      phi_data,
   output logic [ROW_W-1:0]       r_rd_addr,
   input  logic [WORD_W-1:0]      r_rd_data,
   output logic [ROW_W-1:0]       r_wr_addr,
   output logic [WORD_W-1:0]      r_wr_data,
   output logic                   r_we,
   output logic [HIST_W-1:0]      lambda_history,
   output logic                   busy,
   output logic                   update_done,
   output logic                   err
);

   state_t              r_state;
   logic [ROW_W-1:0]    r_row;
   logic [ROW_W-1:0]    r_m;
   logic [COL_W-1:0]    r_lambda;
   logic [ELEM_W-1:0]   r_coeff;
   logic [HIST_W-1:0]   r_hist;
   logic                r_done;
   logic                r_err;

   logic                w_start_ok;
   logic [6:0]          w_slot_base;
   logic                w_ld;
   logic [WORD_W-1:0]   w_lane_d;

   // current_i >= 16 has bit 4 set; that alone rejects the start.
   assign w_start_ok  = (lambda <= N) && !current_i[4];
   assign w_slot_base = 7'(current_i[3:0]) * 7'(SLOT_W);
   assign w_ld        = (r_state == MUL);

   // Sequencer, operand latches and lambda history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_row    <= '0;
         r_m      <= '0;
         r_lambda <= '0;
         r_coeff  <= '0;
         r_hist   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               // Clear first so a same-cycle valid start still lands its slot.
               if (hist_clr)
                  r_hist <= '0;
               if (start_u) begin
                  if (w_start_ok) begin
                     r_lambda <= lambda;
                     r_coeff  <= coeff;
                     r_m      <= M;
                     r_hist[w_slot_base +: SLOT_W] <= {1'b1, lambda};
                     r_row    <= '0;
                     r_state  <= RD;
                  end else begin
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end
               end
            end
            RD:  r_state <= LAT;
            LAT: r_state <= MUL;
            MUL: r_state <= WR;
            WR: begin
               if (r_row == r_m) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_row   <= r_row + 3'd1;
                  r_state <= RD;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_sub_sat u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_ld    (w_ld),
         .i_phi   (phi_data[ELEM_W*g +: ELEM_W]),
         .i_coeff (r_coeff),
         .i_r     (r_rd_data[ELEM_W*g +: ELEM_W]),
         .o_d     (w_lane_d[ELEM_W*g +: ELEM_W])
      );
   end

   assign phi_addr       = {r_lambda, r_row};
   assign r_rd_addr      = r_row;
   assign r_wr_addr      = r_row;
   assign r_we           = (r_state == WR);
   assign r_wr_data      = r_we ? w_lane_d : '0;
   assign lambda_history = r_hist;
   assign busy           = (r_state != IDLE);
   assign update_done    = r_done;
   assign err            = r_err;

endmodule

// File: tb/tb_residual_update.sv
module tb_residual_update;
   import omp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_u = 1'b0;
   logic        hist_clr = 1'b0;
   logic [5:0]  lambda = '0;
   logic [15:0] coeff = '0;
   logic [5:0]  N = '0;
   logic [2:0]  M = '0;
   logic [4:0]  current_i = '0;
   logic [8:0]  phi_addr;
   logic [95:0] phi_data;
   logic [2:0]  r_rd_addr;
   logic [95:0] r_rd_data;
   logic [2:0]  r_wr_addr;
   logic [95:0] r_wr_data;
   logic        r_we;
   logic [111:0] lambda_history;
   logic        busy;
   logic        update_done;
   logic        err;

   residual_update dut (
      .clk(clk), .rst_n(rst_n), .start_u(start_u), .hist_clr(hist_clr),
      .lambda(lambda), .coeff(coeff), .N(N), .M(M), .current_i(current_i),
      .phi_addr(phi_addr), .phi_data(phi_data),
      .r_rd_addr(r_rd_addr), .r_rd_data(r_rd_data),
      .r_wr_addr(r_wr_addr), .r_wr_data(r_wr_data), .r_we(r_we),
      .lambda_history(lambda_history), .busy(busy),
      .update_done(update_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  addr;
      logic [95:0] data;
      logic [8:0]  phia;
   } exp_t;

   exp_t         sb_q[$];
   logic [95:0]  phi_mem [512];
   logic [95:0]  r_mem [8];
   logic         ld_en = 1'b0;
   logic [2:0]   ld_addr = '0;
   logic [95:0]  ld_data = '0;
   logic [111:0] exp_hist = '0;
   int           checks = 0;
   int           errors = 0;
   int           we_cnt = 0;
   int           cyc = 0;
   int           t0 = 0;
   int           we0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM models: one-cycle registered reads; residual write port shared with loader.
   always @(posedge clk) begin
      phi_data  <= phi_mem[phi_addr];
      r_rd_data <= r_mem[r_rd_addr];
      if (r_we)
         r_mem[r_wr_addr] <= r_wr_data;
      else if (ld_en)
         r_mem[ld_addr] <= ld_data;
   end

   function automatic logic [15:0] ref_lane(input logic [15:0] rv, input logic [15:0] ph,
                                            input logic [15:0] c);
      longint prod, q, d;
      prod = longint'($signed(ph)) * longint'($signed(c));
      q = prod / 16384;
      if (prod < 0 && q * 16384 != prod) q = q - 1;
      d = longint'($signed(rv)) - q;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      return 16'(d);
   endfunction

   function automatic logic [95:0] ref_word(input logic [95:0] rw, input logic [95:0] pw,
                                            input logic [15:0] c);
      logic [95:0] w;
      for (int k = 0; k < 6; k++)
         w[16*k +: 16] = ref_lane(rw[16*k +: 16], pw[16*k +: 16], c);
      return w;
   endfunction

   function automatic logic [95:0] r_pat(input int j);
      logic [95:0] w;
      for (int k = 0; k < 6; k++)
         w[16*k +: 16] = 16'((j * 4111 + k * 997 + 4951) ^ (k * 9000));
      return w;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && r_we) begin
         we_cnt++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     r_wr_addr, r_wr_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (r_wr_addr !== e.addr || r_wr_data !== e.data || phi_addr !== e.phia) begin
               errors++;
               $display("FAIL write_row%0d: got addr %0h data %0h phi_addr %0h, expected addr %0h data %0h phi_addr %0h",
                        e.addr, r_wr_addr, r_wr_data, phi_addr, e.addr, e.data, e.phia);
            end
         end
      end
   end

   task automatic load_r(input logic [2:0] row, input logic [95:0] w);
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = row; ld_data = w;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic start_op(input logic [5:0] lam, input logic [15:0] cf, input logic [5:0] n,
                           input logic [2:0] m, input logic [4:0] ci, input logic clr,
                           input int nrows);
      bit ok;
      ok = (lam <= n) && (ci < 16);
      @(posedge clk); #1;
      if (clr) exp_hist = '0;
      if (ok) begin
         exp_hist[7*ci[3:0] +: 7] = {1'b1, lam};
         for (int j = 0; j < nrows; j++) begin
            exp_t e;
            e.addr = 3'(j);
            e.phia = {lam, 3'(j)};
            e.data = ref_word(r_mem[j], phi_mem[{lam, 3'(j)}], cf);
            sb_q.push_back(e);
         end
      end
      start_u = 1'b1; hist_clr = clr; lambda = lam; coeff = cf; N = n; M = m; current_i = ci;
      @(posedge clk); #1;
      start_u = 1'b0; hist_clr = 1'b0;
      t0 = cyc - 1;
      we0 = we_cnt;
   endtask

   task automatic pulse_only(input logic [5:0] lam, input logic [15:0] cf, input logic [4:0] ci);
      @(posedge clk); #1;
      start_u = 1'b1; hist_clr = 1'b1; lambda = lam; coeff = cf; current_i = ci;
      @(posedge clk); #1;
      start_u = 1'b0; hist_clr = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat, input logic exp_err);
      int n;
      n = 0;
      while (!update_done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!update_done) begin
         chk({name, "_timeout"}, 0, 1);
      end else begin
         chk({name, "_latency"}, 128'(cyc - t0), 128'(exp_lat));
         chk({name, "_err"}, err, exp_err);
         @(posedge clk); #1;
         chk({name, "_done_pulse"}, update_done, 1'b0);
         chk({name, "_idle"}, busy, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] w;
      for (int a = 0; a < 512; a++)
         for (int k = 0; k < 6; k++)
            phi_mem[a][16*k +: 16] = 16'(a * 911 + k * 7717 + 123);
      phi_mem[{6'd5, 3'd0}][15:0]   = 16'h1000;
      phi_mem[{6'd12, 3'd0}][31:16] = 16'h7FFF;
      phi_mem[{6'd12, 3'd0}][47:32] = 16'h8000;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_we", r_we, 1'b0);
      chk("reset_done", update_done, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_hist", lambda_history, '0);
      chk("reset_phi_addr", phi_addr, '0);
      rst_n = 1'b1;

      // Basic update, M=1
      for (int j = 0; j < 8; j++) begin
         w = r_pat(j);
         if (j == 0) w[15:0] = 16'h3000;
         load_r(3'(j), w);
      end
      start_op(6'd5, 16'h4000, 6'd63, 3'd1, 5'd0, 1'b0, 2);
      wait_done("basic", 9, 1'b0);
      chk("basic_we_count", 128'(we_cnt - we0), 128'd2);
      chk("basic_sb_empty", 128'(sb_q.size()), 128'd0);
      chk("basic_lane0_row0", r_mem[0][15:0], 16'h2000);
      chk("basic_hist", lambda_history, exp_hist);

      // Saturation in both directions
      w = r_pat(0);
      w[31:16] = 16'h8000;
      w[47:32] = 16'h7FFF;
      load_r(3'd0, w);
      start_op(6'd12, 16'h4000, 6'd63, 3'd1, 5'd1, 1'b0, 2);
      wait_done("sat", 9, 1'b0);
      chk("sat_neg", r_mem[0][31:16], 16'h8000);
      chk("sat_pos", r_mem[0][47:32], 16'h7FFF);
      chk("sat_sb_empty", 128'(sb_q.size()), 128'd0);

      // History slots 0, 1, 15
      start_op(6'd3, 16'h1234, 6'd63, 3'd1, 5'd0, 1'b0, 2);
      wait_done("hist0", 9, 1'b0);
      start_op(6'd63, 16'hC000, 6'd63, 3'd1, 5'd1, 1'b0, 2);
      wait_done("hist1", 9, 1'b0);
      start_op(6'd10, 16'h0800, 6'd63, 3'd1, 5'd15, 1'b0, 2);
      wait_done("hist15", 9, 1'b0);
      chk("hist_slot0", lambda_history[6:0], 7'h43);
      chk("hist_slot1", lambda_history[13:7], 7'h7F);
      chk("hist_slot15", lambda_history[111:105], 7'h4A);
      chk("hist_all", lambda_history, exp_hist);
      @(posedge clk); #1;
      hist_clr = 1'b1;
      @(posedge clk); #1;
      hist_clr = 1'b0;
      exp_hist = '0;
      chk("hist_clr", lambda_history, '0);

      // Clear together with a valid start: clear first, then new slot
      start_op(6'd7, 16'h2000, 6'd63, 3'd1, 5'd2, 1'b1, 2);
      wait_done("clr_start", 9, 1'b0);
      chk("clr_start_hist", lambda_history, 112'h47 << 14);

      // Rejected starts
      start_op(6'd20, 16'h4000, 6'd15, 3'd1, 5'd0, 1'b0, 2);
      wait_done("rej_lambda", 1, 1'b1);
      chk("rej_lambda_we", 128'(we_cnt - we0), 128'd0);
      chk("rej_lambda_hist", lambda_history, exp_hist);
      start_op(6'd3, 16'h4000, 6'd63, 3'd1, 5'd16, 1'b0, 2);
      wait_done("rej_slot", 1, 1'b1);
      chk("rej_slot_we", 128'(we_cnt - we0), 128'd0);
      chk("rej_slot_hist", lambda_history, exp_hist);

      // Start and hist_clr while busy are ignored
      start_op(6'd5, 16'h2000, 6'd63, 3'd1, 5'd4, 1'b0, 2);
      pulse_only(6'd9, 16'h7FFF, 5'd5);
      wait_done("midop", 9, 1'b0);
      chk("midop_we_count", 128'(we_cnt - we0), 128'd2);
      chk("midop_sb_empty", 128'(sb_q.size()), 128'd0);
      chk("midop_hist", lambda_history, exp_hist);

      // Reset during LAT of row 3, M=7
      for (int j = 0; j < 8; j++) load_r(3'(j), r_pat(j));
      start_op(6'd2, 16'h3000, 6'd63, 3'd7, 5'd3, 1'b0, 3);
      repeat (13) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      exp_hist = '0;
      chk("abort_we", r_we, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_phi_addr", phi_addr, '0);
      chk("abort_wr_data", r_wr_data, '0);
      chk("abort_hist", lambda_history, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_we_count", 128'(we_cnt - we0), 128'd3);
      chk("abort_sb_empty", 128'(sb_q.size()), 128'd0);
      for (int j = 0; j < 3; j++)
         chk("abort_row_updated", r_mem[j], ref_word(r_pat(j), phi_mem[{6'd2, 3'(j)}], 16'h3000));
      for (int j = 3; j < 8; j++)
         chk("abort_row_untouched", r_mem[j], r_pat(j));
      rst_n = 1'b1;
      start_op(6'd2, 16'h3000, 6'd63, 3'd7, 5'd0, 1'b0, 8);
      wait_done("post_reset", 33, 1'b0);
      chk("post_reset_we_count", 128'(we_cnt - we0), 128'd8);
      chk("post_reset_sb_empty", 128'(sb_q.size()), 128'd0);
      chk("post_reset_hist", lambda_history, exp_hist);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/residual_update.md
Name: residual_update

Overview:
- Write-side companion to the OMP atom-selection stage, which only reads phi and r.
- After a lambda is chosen, this block rewrites the residual BRAM in place: r[k] <= sat16(r[k] - ((phi_lambda[k]*coeff) >>> FRAC)).
- It also appends lambda to the masking history consumed by the selection stage.
- It sits between the OMP controller and the r BRAM write port, sharing the phi read port under controller arbitration.

Parameters:
- LANES, 6, signed 16-bit elements per 96-bit BRAM word (lane k at bits [16k+15:16k]).
- FRAC, 14, fractional bits of the Q2.14 element format.
- HIST_SLOTS, 16, lambda history depth; each slot is 7 bits {valid, lambda[5:0]}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_u  in  1  one-cycle start pulse; ignored unless IDLE
- hist_clr  in  1  synchronous clear of lambda_history; only acted on in IDLE
- lambda  in  6  selected column index, sampled at start_u
- coeff  in  16  signed Q2.14 update coefficient, sampled at start_u
- N  in  6  last valid column index (15 or 63), sampled at start_u
- M  in  3  last residual row (1 or 7), sampled at start_u
- current_i  in  5  OMP iteration; selects the history slot, sampled at start_u
- phi_addr  out  9  {lambda, row}
- phi_data  in  96  phi word, valid 1 cycle after phi_addr
- r_rd_addr  out  3  residual read row
- r_rd_data  in  96  residual word, valid 1 cycle after r_rd_addr
- r_wr_addr  out  3  residual write row
- r_wr_data  out  96  updated residual word
- r_we  out  1  residual write strobe
- lambda_history  out  112  slot i at bits [7i+6:7i]
- busy  out  1  high in any state except IDLE
- update_done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (asynchronous): all outputs 0, history 0, state IDLE, row 0.
- IDLE, start_u=1 with lambda<=N and current_i<HIST_SLOTS:
  - latch lambda, coeff, M and current_i;
  - write slot current_i <= {1, lambda}, visible the next cycle;
  - row <= 0; go to RD.
- IDLE, start_u=1 with lambda>N or current_i>=16:
  - no history change and no BRAM write;
  - err and update_done both pulse the next cycle; stay IDLE.
- RD: drive phi_addr={lambda,row} and r_rd_addr=row; go to LAT.
- LAT: BRAM latency cycle; addresses held; go to MUL.
- MUL, per lane:
  - register p = phi*coeff as 32-bit signed;
  - register r from BRAM;
  - go to WR.
- WR, per lane:
  - d = r - (p >>> FRAC), computed 18-bit signed; shift is arithmetic, truncating toward -inf;
  - saturate d to [-32768, 32767];
  - drive r_wr_data and r_wr_addr=row with r_we=1 for exactly this cycle.
  - If row==M, go to DONE; otherwise row++ and go to RD.
- DONE: update_done=1 for one cycle; go to IDLE.
- Latency: start_u to update_done = 4*(M+1)+1 cycles, i.e. 9 for M=1 and 33 for M=7.
- Row order: writes to row j always occur after reads of row j, and rows are strictly ascending, so there is no read-after-write hazard.
- start_u while busy is ignored; the latched operands stay unchanged.
- hist_clr in IDLE zeroes all slots. If asserted together with a valid start_u, the clear applies first and the new slot is then written.
- hist_clr while busy is ignored.
- Re-writing an already valid slot overwrites it.
- rst_n low mid-operation aborts immediately with no further r_we; partially updated rows are left as written.

Decomposition:
- Shared package omp_pkg holds:
  - element width 16, FRAC 14, LANES 6, word width 96;
  - history slot width 7 and HIST_SLOTS 16;
  - row and column address widths 3 and 6;
  - the state encoding IDLE/RD/LAT/MUL/WR/DONE.
- One sub-module, lane_sub_sat: a single lane of multiply, shift, subtract and saturate, instantiated LANES times, with the product register inside.

Test Plan:
- M=1, lambda=5, coeff=0x4000 (1.0), phi row0 lane0=0x1000, r row0 lane0=0x3000 -> r_we on rows 0,1 at addr 0/1; lane0 row0 written 0x2000; update_done 9 cycles after start_u; phi_addr reads 0x028 then 0x029.
- Saturation: r=0x8000, phi=0x7FFF, coeff=0x4000 -> written 0x8000. Also r=0x7FFF, phi=0x8000 -> written 0x7FFF.
- History: three updates with current_i=0,1,15 and lambda=3,63,10 (N=63) -> lambda_history[6:0]=0x43, [13:7]=0x7F, [111:105]=0x4A. Then hist_clr -> all zero.
- Reject cases: N=15, lambda=20 -> err and update_done pulse the next cycle; no r_we; history unchanged. Same result for current_i=16.
- start_u pulsed mid-operation with lambda=9 -> ignored; all writes use the original lambda; exactly M+1 r_we pulses.
- rst_n asserted during the LAT state of row 3 (M=7) -> outputs 0 immediately; rows 0-2 updated, rows 3-7 untouched; a new start after reset completes normally.
